// File: rtl/alu_stream_engine.sv
`default_nettype none
// ============================================================================
// Module      : alu_stream_engine
// Description : Streaming arithmetic engine. Commands enter an input FIFO,
//               are executed one at a time by a multi-cycle ALU
//               (ADD/SUB/MUL/DIV), and results leave through a first-word
//               fall-through output FIFO in strict command order.
//               Optional feature macro ALU_STREAM_ERR_EN adds a per-result
//               divide-by-zero flag (m_err).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_stream_engine #(
    parameter int W          = 4,
    parameter int IN_DEPTH   = 8,
    parameter int OUT_DEPTH  = 8,
    parameter int MD_LATENCY = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [2*W+1:0]               s_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [2*W-1:0]               m_data,
`ifdef ALU_STREAM_ERR_EN
    output logic                         m_err,
`endif
    output logic [$clog2(IN_DEPTH):0]    in_count,
    output logic [$clog2(OUT_DEPTH):0]   out_count,
    output logic                         busy
);

    localparam int c_IN_AW  = $clog2(IN_DEPTH);
    localparam int c_OUT_AW = $clog2(OUT_DEPTH);
    localparam int c_CW     = $clog2(MD_LATENCY + 1);
`ifdef ALU_STREAM_ERR_EN
    localparam int c_OUT_DW = 2*W + 1;
`else
    localparam int c_OUT_DW = 2*W;
`endif
    localparam logic [c_IN_AW:0]  c_IN_FULL  = (c_IN_AW + 1)'(IN_DEPTH);
    localparam logic [c_OUT_AW:0] c_OUT_FULL = (c_OUT_AW + 1)'(OUT_DEPTH);
    localparam logic [c_CW-1:0]   c_MD_CNT   = c_CW'(MD_LATENCY - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    logic [2*W+1:0]     r_in_mem [IN_DEPTH];
    logic [c_IN_AW-1:0] r_in_wr;
    logic [c_IN_AW-1:0] r_in_rd;
    logic [c_IN_AW:0]   r_in_count;
    logic               w_in_full;
    logic               w_in_empty;
    logic               w_in_push;
    logic               w_in_pop;
    logic [2*W+1:0]     w_in_head;

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [c_OUT_DW-1:0] r_out_mem [OUT_DEPTH];
    logic [c_OUT_AW-1:0] r_out_wr;
    logic [c_OUT_AW-1:0] r_out_rd;
    logic [c_OUT_AW:0]   r_out_count;
    logic                w_out_full;
    logic                w_out_empty;
    logic                w_out_push;
    logic                w_out_pop;
    logic [c_OUT_DW-1:0] w_out_din;
    logic [c_OUT_DW-1:0] w_out_head;

    // ------------------------------------------------------------------
    // ALU state
    // ------------------------------------------------------------------
    state_t          r_state;
    logic [c_CW-1:0] r_cnt;
    logic [1:0]      r_op;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [2*W-1:0]  w_result;
    logic [W-1:0]    w_quo;
    logic [W-1:0]    w_rem;
    logic [2*W-1:0]  w_a_ext;
    logic [2*W-1:0]  w_b_ext;
    logic            w_div_zero;

    assign w_in_full  = (r_in_count == c_IN_FULL);
    assign w_in_empty = (r_in_count == '0);
    assign w_out_full  = (r_out_count == c_OUT_FULL);
    assign w_out_empty = (r_out_count == '0);

    // s_ready is held low for as long as reset is asserted
    assign s_ready   = !reset && !w_in_full;
    assign w_in_push = s_valid && s_ready;
    assign w_in_head = r_in_mem[r_in_rd];

    // ALU takes a command only when it is idle and a result slot is free;
    // the out FIFO cannot shrink its free space afterwards, so the later push is safe.
    assign w_in_pop = (r_state == S_IDLE) && !w_in_empty && !w_out_full;

    assign m_valid    = !w_out_empty;
    assign w_out_pop  = m_valid && m_ready;
    assign w_out_push = (r_state == S_EXEC) && (r_cnt == '0);
    assign w_out_head = r_out_mem[r_out_rd];
    assign m_data     = w_out_empty ? '0 : w_out_head[2*W-1:0];
`ifdef ALU_STREAM_ERR_EN
    assign m_err      = w_out_empty ? 1'b0 : w_out_head[2*W];
    assign w_out_din  = {w_div_zero, w_result};
`else
    assign w_out_din  = w_result;
`endif

    assign in_count  = r_in_count;
    assign out_count = r_out_count;
    assign busy      = (r_state == S_EXEC);

    // Input FIFO storage write (no reset needed; occupancy guards reads)
    always_ff @(posedge clk) begin
        if (w_in_push) begin
            r_in_mem[r_in_wr] <= s_data;
        end
    end

    // Input FIFO pointers and occupancy; simultaneous push/pop leaves count unchanged
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_wr    <= '0;
            r_in_rd    <= '0;
            r_in_count <= '0;
        end else begin
            if (w_in_push) begin
                r_in_wr <= r_in_wr + 1'b1;
            end
            if (w_in_pop) begin
                r_in_rd <= r_in_rd + 1'b1;
            end
            if (w_in_push && !w_in_pop) begin
                r_in_count <= r_in_count + 1'b1;
            end else if (!w_in_push && w_in_pop) begin
                r_in_count <= r_in_count - 1'b1;
            end
        end
    end

    // Output FIFO storage write
    always_ff @(posedge clk) begin
        if (w_out_push) begin
            r_out_mem[r_out_wr] <= w_out_din;
        end
    end

    // Output FIFO pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_wr    <= '0;
            r_out_rd    <= '0;
            r_out_count <= '0;
        end else begin
            if (w_out_push) begin
                r_out_wr <= r_out_wr + 1'b1;
            end
            if (w_out_pop) begin
                r_out_rd <= r_out_rd + 1'b1;
            end
            if (w_out_push && !w_out_pop) begin
                r_out_count <= r_out_count + 1'b1;
            end else if (!w_out_push && w_out_pop) begin
                r_out_count <= r_out_count - 1'b1;
            end
        end
    end

    // ALU control: latch a command in IDLE, count down execute cycles in EXEC
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_in_pop) begin
                        r_op    <= w_in_head[2*W+1:2*W];
                        r_b     <= w_in_head[2*W-1:W];
                        r_a     <= w_in_head[W-1:0];
                        // op[1] set means MUL or DIV
                        r_cnt   <= w_in_head[2*W+1] ? c_MD_CNT : '0;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (r_cnt == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Result datapath from the latched operands; divide by zero yields
    // an all-ones quotient and the dividend as remainder
    always_comb begin
        w_a_ext    = {{W{1'b0}}, r_a};
        w_b_ext    = {{W{1'b0}}, r_b};
        w_div_zero = (r_op == 2'd3) && (r_b == '0);
        w_quo      = (r_b == '0) ? '1  : (r_a / r_b);
        w_rem      = (r_b == '0) ? r_a : (r_a % r_b);
        w_result   = '0;
        case (r_op)
            2'd0:    w_result = w_a_ext + w_b_ext;
            2'd1:    w_result = w_a_ext - w_b_ext;
            2'd2:    w_result = w_a_ext * w_b_ext;
            default: w_result = {w_rem, w_quo};
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_stream_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_stream_engine
// Description : Self-checking bench for alu_stream_engine. A result queue
//               model predicts every output; directed vectors pin latency,
//               backpressure, full-FIFO and reset behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_stream_engine;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           s_valid;
    logic           s_ready;
    logic [2*W+1:0] s_data;
    logic           m_valid;
    logic           m_ready;
    logic [2*W-1:0] m_data;
`ifdef ALU_STREAM_ERR_EN
    logic           m_err;
`endif
    logic [3:0]     in_count;
    logic [3:0]     out_count;
    logic           busy;

    int checks   = 0;
    int failures = 0;
    int n_recv   = 0;

    logic [2*W-1:0] exp_q[$];
    logic           err_q[$];

    alu_stream_engine #(
        .W          (4),
        .IN_DEPTH   (8),
        .OUT_DEPTH  (8),
        .MD_LATENCY (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
`ifdef ALU_STREAM_ERR_EN
        .m_err     (m_err),
`endif
        .in_count  (in_count),
        .out_count (out_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    // Arithmetic model: plain integer maths on the command fields
    function automatic logic [2*W-1:0] model_result(input logic [2*W+1:0] d);
        int op, a, b, r, m, h;
        op = int'(d[2*W+1:2*W]);
        b  = int'(d[2*W-1:W]);
        a  = int'(d[W-1:0]);
        m  = 1 << (2*W);
        h  = 1 << W;
        case (op)
            0:       r = a + b;
            1:       r = (a - b + m) % m;
            2:       r = a * b;
            default: r = (b == 0) ? (a * h + (h - 1)) : ((a % b) * h + a / b);
        endcase
        return r[2*W-1:0];
    endfunction

    // Compare process: every cycle the head is checked against the model queue
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            err_q.delete();
        end else begin
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_m_valid: got m_valid=1 data=0x%0h, expected no result pending", m_data);
                end else begin
                    check("stream_m_data", int'(m_data), int'(exp_q[0]));
`ifdef ALU_STREAM_ERR_EN
                    check("stream_m_err", int'(m_err), int'(err_q[0]));
`endif
                    if (m_ready) begin
                        void'(exp_q.pop_front());
                        void'(err_q.pop_front());
                        n_recv++;
                    end
                end
            end
            if (s_valid && s_ready) begin
                exp_q.push_back(model_result(s_data));
                err_q.push_back((s_data[2*W+1:2*W] == 2'd3) && (s_data[2*W-1:W] == '0));
            end
        end
    end

    // Offer one command until accepted; returns #1 after the accepting edge
    task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic ok;
        int   n;
        ok = 1'b0;
        n  = 0;
        s_data  = {op, b, a};
        s_valid = 1'b1;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
            n++;
        end
        #1;
        s_valid = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got no accept in %0d cycles, expected accept", n);
        end
    endtask

    // Wait for m_valid counting edges since the accept, then check latency and value
    task automatic expect_result(input string name, input int lat, input int data);
        int k;
        k = 0;
        while (!m_valid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({name, "_latency"}, k, lat);
        check({name, "_data"}, int'(m_data), data);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int sent;
        int base;
        int c;
        logic ok;

        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", int'(s_ready), 0);
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_m_data", int'(m_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_in_count", int'(in_count), 0);
        check("rst_out_count", int'(out_count), 0);
        reset = 1'b0;
        #1;
        check("release_s_ready", int'(s_ready), 1);
        @(posedge clk);
        #1;

        // Directed arithmetic with hand-computed values
        send(2'd0, 4'd9, 4'd7);
        expect_result("add_9_7", 2, 8'h10);
        send(2'd1, 4'd3, 4'd5);
        expect_result("sub_3_5", 2, 8'hFE);
        send(2'd2, 4'd15, 4'd15);
        expect_result("mul_15_15", 4, 8'hE1);
        send(2'd3, 4'd13, 4'd4);
        expect_result("div_13_4", 4, 8'h13);
        send(2'd3, 4'd5, 4'd0);
`ifdef ALU_STREAM_ERR_EN
        check("div0_m_err_pre", int'(m_err), 0);
`endif
        expect_result("div_5_0", 4, 8'h5F);

        // Backpressure: m_ready low, stream 20 ADDs
        base    = n_recv;
        m_ready = 1'b0;
        sent    = 0;
        c       = 0;
        while (sent < 20 && c < 50) begin
            s_data  = {2'd0, 4'(((sent + 1) >> 4) + 3), 4'((sent + 1) & 15)};
            s_valid = 1'b1;
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
            #1;
            if (ok) sent++;
            c++;
        end
        s_data = {2'd0, 4'(((sent + 1) >> 4) + 3), 4'((sent + 1) & 15)};
        check("bp_accepted", sent, 16);
        check("bp_in_count", int'(in_count), 8);
        check("bp_out_count", int'(out_count), 8);
        check("bp_s_ready", int'(s_ready), 0);

        // Release the sink while the input FIFO is full and a push is offered
        m_ready = 1'b1;
        @(negedge clk);
        check("full_same_cycle_s_ready", int'(s_ready), 0);
        @(posedge clk);
        #1;
        check("full_same_cycle_in_count", int'(in_count), 8);
        check("full_same_cycle_out_count", int'(out_count), 7);

        c = 0;
        while (sent < 20 && c < 100) begin
            s_data  = {2'd0, 4'(((sent + 1) >> 4) + 3), 4'((sent + 1) & 15)};
            s_valid = 1'b1;
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
            #1;
            if (ok) sent++;
            c++;
        end
        s_valid = 1'b0;
        check("bp_all_sent", sent, 20);
        c = 0;
        while ((m_valid || busy || in_count != 0) && c < 200) begin
            @(posedge clk);
            #1;
            c++;
        end
        @(negedge clk);
        @(posedge clk);
        #1;
        check("bp_received", n_recv - base, 20);
        check("bp_drained_out_count", int'(out_count), 0);

        // Reset asserted two cycles into a MUL with a second command queued
        send(2'd2, 4'd7, 4'd6);
        s_data  = {2'd0, 4'd1, 4'd2};
        s_valid = 1'b1;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        check("mid_mul_busy", int'(busy), 1);
        check("mid_mul_in_count", int'(in_count), 1);
        reset = 1'b1;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_m_valid", int'(m_valid), 0);
        check("arst_in_count", int'(in_count), 0);
        check("arst_out_count", int'(out_count), 0);
        check("arst_s_ready", int'(s_ready), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("arst_release_s_ready", int'(s_ready), 1);
        repeat (10) @(posedge clk);
        #1;
        check("no_stale_m_valid", int'(m_valid), 0);
        check("no_stale_busy", int'(busy), 0);

        // Model sanity after reset: one more command end to end
        send(2'd3, 4'd15, 4'd2);
        expect_result("div_15_2", 4, 8'h17);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
